// File: rtl/bmatch_vec_driver.sv
// rtl/bmatch_vec_driver.sv - exhaustive vector driver and mapping checker for Boolean matching
//
// Purpose: walks every NI-bit input vector, drives cir1 with it directly and
// cir2 through a latched input permutation/negation, then compares the two
// responses through a latched output permutation/negation. Reports whether
// the candidate mapping is a match, the first failing vector and the number
// of failing vectors.
//
// Optional feature: define BMATCH_EARLY_ABORT_EN to end the run at the first
// mismatching compare (mismatch_cnt then reads 1).
//
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   start               begin a run (sampled only when idle)
//   iperm, ineg         cir2 input i = vec_a[iperm field i] ^ ineg[i]
//   operm, oneg         cir1 output j is checked against cir2 output operm field j ^ oneg[j]
//   vec_a, vec_b        registered stimulus to cir1 / cir2
//   resp_a, resp_b      combinational responses of cir1 / cir2
//   busy, done          run in progress / one-cycle end-of-run pulse
//   match               held result of the last run
//   fail_valid,fail_vec first mismatching vector of the last run
//   mismatch_cnt        number of mismatching vectors in the last run
module bmatch_vec_driver #(
  parameter int NI  = 4,
  parameter int NO  = 2,
  parameter int IPW = $clog2(NI),
  parameter int OPW = $clog2(NO)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NI*IPW-1:0] iperm,
  input  logic [NI-1:0]     ineg,
  input  logic [NO*OPW-1:0] operm,
  input  logic [NO-1:0]     oneg,
  output logic [NI-1:0]     vec_a,
  output logic [NI-1:0]     vec_b,
  input  logic [NO-1:0]     resp_a,
  input  logic [NO-1:0]     resp_b,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic              fail_valid,
  output logic [NI-1:0]     fail_vec,
  output logic [NI:0]       mismatch_cnt
);

`ifdef BMATCH_EARLY_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  localparam logic [NI-1:0] VEC_ONE = NI'(1);
  localparam logic [NI:0]   CNT_ONE = (NI+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  // Configuration captured at start so the inputs may change during a run.
  logic [NI*IPW-1:0] iperm_q;
  logic [NI-1:0]     ineg_q;
  logic [NO*OPW-1:0] operm_q;
  logic [NO-1:0]     oneg_q;

  logic [NI-1:0]     cnt;          // next vector to drive
  logic              drive_valid;  // vec_a/vec_b hold a vector of this run
  logic              cap_valid;    // capture registers hold a vector to compare
  logic [NO-1:0]     cap_a;
  logic [NO-1:0]     cap_b;
  logic [NI-1:0]     cap_tag;
  logic              cmp_hit;

  // Out-of-range permutation indices fall back to bit 0.
  function automatic logic [NI-1:0] map_in(input logic [NI-1:0]     v,
                                           input logic [NI*IPW-1:0] perm,
                                           input logic [NI-1:0]     neg);
    logic [NI-1:0]  r;
    logic [IPW-1:0] idx;
    r = '0;
    for (int i = 0; i < NI; i++) begin
      idx  = perm[i*IPW +: IPW];
      r[i] = ((int'(idx) < NI) ? v[idx] : v[0]) ^ neg[i];
    end
    return r;
  endfunction

  function automatic logic out_mismatch(input logic [NO-1:0]     ra,
                                        input logic [NO-1:0]     rb,
                                        input logic [NO*OPW-1:0] perm,
                                        input logic [NO-1:0]     neg);
    logic           m;
    logic           sel;
    logic [OPW-1:0] idx;
    m = 1'b0;
    for (int j = 0; j < NO; j++) begin
      idx = perm[j*OPW +: OPW];
      sel = (int'(idx) < NO) ? rb[idx] : rb[0];
      if (ra[j] != (sel ^ neg[j])) m = 1'b1;
    end
    return m;
  endfunction

  // In abort mode nothing is compared once the first failure is recorded,
  // so the captured vectors still in flight are discarded.
  assign cmp_hit = cap_valid && !(ABORT && fail_valid) &&
                   out_mismatch(cap_a, cap_b, operm_q, oneg_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        if (ABORT && fail_valid)  state_nx = DONE;
        else if (cnt == '1)       state_nx = DRAIN;
      end
      DRAIN: begin
        if (ABORT && fail_valid)            state_nx = DONE;
        else if (!drive_valid && !cap_valid) state_nx = DONE;
      end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == RUN) || (state == DRAIN);
    done = (state == DONE);
  end

  // Datapath: drive -> capture -> compare, one stage per edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      iperm_q      <= '0;
      ineg_q       <= '0;
      operm_q      <= '0;
      oneg_q       <= '0;
      cnt          <= '0;
      vec_a        <= '0;
      vec_b        <= '0;
      drive_valid  <= 1'b0;
      cap_valid    <= 1'b0;
      cap_a        <= '0;
      cap_b        <= '0;
      cap_tag      <= '0;
      match        <= 1'b0;
      fail_valid   <= 1'b0;
      fail_vec     <= '0;
      mismatch_cnt <= '0;
    end else if (state == IDLE && start) begin
      iperm_q      <= iperm;
      ineg_q       <= ineg;
      operm_q      <= operm;
      oneg_q       <= oneg;
      cnt          <= '0;
      vec_a        <= '0;
      vec_b        <= ineg;  // vector 0 through the new mapping
      drive_valid  <= 1'b0;
      cap_valid    <= 1'b0;
      match        <= 1'b0;
      fail_valid   <= 1'b0;
      fail_vec     <= '0;
      mismatch_cnt <= '0;
    end else begin
      drive_valid <= (state == RUN);
      if (state == RUN) begin
        vec_a <= cnt;
        vec_b <= map_in(cnt, iperm_q, ineg_q);
        cnt   <= cnt + VEC_ONE;
      end

      cap_valid <= drive_valid;
      if (drive_valid) begin
        cap_a   <= resp_a;
        cap_b   <= resp_b;
        cap_tag <= vec_a;
      end

      if (cmp_hit) begin
        mismatch_cnt <= mismatch_cnt + CNT_ONE;
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_vec   <= cap_tag;
        end
      end

      // The count is final on the edge that enters DONE.
      if (state_nx == DONE && state != DONE) begin
        match       <= (mismatch_cnt == '0);
        drive_valid <= 1'b0;
        cap_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bmatch_vec_driver.sv
// tb/tb_bmatch_vec_driver.sv - self-checking bench for bmatch_vec_driver
module tb_bmatch_vec_driver;

  localparam int NI = 4;
  localparam int NO = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    iperm;
  logic [3:0]    ineg;
  logic [1:0]    operm;
  logic [1:0]    oneg;
  logic [3:0]    vec_a;
  logic [3:0]    vec_b;
  logic [1:0]    resp_a;
  logic [1:0]    resp_b;
  logic          busy;
  logic          done;
  logic          match;
  logic          fail_valid;
  logic [3:0]    fail_vec;
  logic [4:0]    mismatch_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Bench-side mapping and CUT truth tables.
  int         iperm_a [4];
  int         operm_a [2];
  logic [3:0] ineg_v;
  logic [1:0] oneg_v;
  logic [1:0] tab_a [16];
  logic [1:0] tab_b [16];

  bmatch_vec_driver #(.NI(NI), .NO(NO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .iperm(iperm), .ineg(ineg), .operm(operm), .oneg(oneg),
    .vec_a(vec_a), .vec_b(vec_b), .resp_a(resp_a), .resp_b(resp_b),
    .busy(busy), .done(done), .match(match),
    .fail_valid(fail_valid), .fail_vec(fail_vec), .mismatch_cnt(mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    iperm = '0;
    operm = '0;
    for (int i = 0; i < 4; i++) iperm[i*2 +: 2] = 2'(iperm_a[i]);
    for (int j = 0; j < 2; j++) operm[j] = 1'(operm_a[j]);
    ineg = ineg_v;
    oneg = oneg_v;
  end

  assign resp_a = tab_a[vec_a];
  assign resp_b = tab_b[vec_b];

  function automatic logic [3:0] vb_of(input logic [3:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[iperm_a[i]] ^ ineg_v[i];
    return r;
  endfunction

  // Reference: try every vector against the mapping, then apply run rules.
  task automatic model(output int e_off, output int e_cnt, output int e_fvld,
                       output int e_fv, output int e_match);
    int n, first;
    logic [1:0] ra, rb;
    n = 0; first = -1;
    for (int v = 0; v < 16; v++) begin
      bit bad;
      ra = tab_a[v];
      rb = tab_b[vb_of(4'(v))];
      bad = 0;
      for (int j = 0; j < 2; j++) if (ra[j] != (rb[operm_a[j]] ^ oneg_v[j])) bad = 1;
      if (bad) begin n++; if (first < 0) first = v; end
    end
    e_fvld  = (n > 0);
    e_fv    = (n > 0) ? first : 0;
    e_match = (n == 0);
`ifdef BMATCH_EARLY_ABORT_EN
    e_cnt = (n > 0) ? 1 : 0;
    e_off = (n > 0) ? first + 4 : 19;
`else
    e_cnt = n;
    e_off = 19;
`endif
  endtask

  // Starts a run and watches it; returns the done offset (-1 on timeout),
  // whether vec_a/vec_b followed the vector schedule, and whether busy/done framed the run.
  task automatic run_dut(output int off, output bit seq_ok, output bit pulse_ok);
    int k, o;
    seq_ok = 1; pulse_ok = 1; off = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; k = cyc;
    if (busy !== 1'b1) pulse_ok = 0;
    for (int n = 0; n < 40 && off < 0; n++) begin
      o = cyc - k;
      if (o >= 1 && o <= 16)
        if (vec_a !== 4'(o - 1) || vec_b !== vb_of(4'(o - 1))) seq_ok = 0;
      if (done === 1'b1) begin
        off = o;
        if (busy !== 1'b0) pulse_ok = 0;
      end else begin
        @(negedge clk);
      end
    end
    if (off >= 0) begin
      @(negedge clk);
      if (done !== 1'b0) pulse_ok = 0;
    end
  endtask

  task automatic set_identity();
    for (int i = 0; i < 4; i++) iperm_a[i] = i;
    operm_a[0] = 0; operm_a[1] = 1;
    ineg_v = 4'b0000; oneg_v = 2'b00;
    for (int v = 0; v < 16; v++) begin
      logic [3:0] x;
      x = 4'(v);
      tab_a[v] = {(x[0] & x[2]) | (x[1] & (~x[0] | x[3])), x[0] & x[1]};
      tab_b[v] = tab_a[v];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    set_identity();
    repeat (3) @(negedge clk);
    tests++;
    if ({vec_a, vec_b, busy, done, match, fail_valid, fail_vec, mismatch_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {vec_a, vec_b, busy, done, match, fail_valid, fail_vec, mismatch_cnt});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    int off; bit sq, pl;
    set_identity();
    run_dut(off, sq, pl);
    tests++; if (off != 19) begin fails++; $display("FAIL ident_done_off: got %0d expected 19", off); end
    tests++; if (!sq) begin fails++; $display("FAIL ident_sequence: got 0 expected 1"); end
    tests++; if (!pl) begin fails++; $display("FAIL ident_busy_done: got 0 expected 1"); end
    tests++; if (match !== 1'b1) begin fails++; $display("FAIL ident_match: got %b expected 1", match); end
    tests++; if (mismatch_cnt !== 5'd0) begin fails++; $display("FAIL ident_cnt: got %0d expected 0", mismatch_cnt); end
    tests++; if (fail_valid !== 1'b0) begin fails++; $display("FAIL ident_fail_valid: got %b expected 0", fail_valid); end
  endtask

  task automatic test_input_swap();
    int off; bit sq, pl;
    set_identity();
    iperm_a[0] = 1; iperm_a[1] = 0;
    for (int v = 0; v < 16; v++) begin
      logic [3:0] x;
      x = 4'(v);
      tab_b[v] = tab_a[{x[3], x[2], x[0], x[1]}];
    end
    run_dut(off, sq, pl);
    tests++; if (off != 19) begin fails++; $display("FAIL swap_done_off: got %0d expected 19", off); end
    tests++; if (!sq) begin fails++; $display("FAIL swap_sequence: got 0 expected 1"); end
    tests++; if (match !== 1'b1) begin fails++; $display("FAIL swap_match: got %b expected 1", match); end
    tests++; if (mismatch_cnt !== 5'd0) begin fails++; $display("FAIL swap_cnt: got %0d expected 0", mismatch_cnt); end
  endtask

  task automatic test_wrong_neg();
    int off, e_off, e_cnt; bit sq, pl;
    set_identity();
    for (int v = 0; v < 16; v++) begin
      logic [3:0] x;
      x = 4'(v);
      tab_a[v] = {1'b0, x[0] & x[1]};
      tab_b[v] = tab_a[v];
    end
    ineg_v = 4'b0001;
`ifdef BMATCH_EARLY_ABORT_EN
    e_off = 6; e_cnt = 1;
`else
    e_off = 19; e_cnt = 8;
`endif
    run_dut(off, sq, pl);
    tests++; if (off != e_off) begin fails++; $display("FAIL neg_done_off: got %0d expected %0d", off, e_off); end
    tests++; if (!sq) begin fails++; $display("FAIL neg_sequence: got 0 expected 1"); end
    tests++; if (!pl) begin fails++; $display("FAIL neg_busy_done: got 0 expected 1"); end
    tests++; if (mismatch_cnt !== 5'(e_cnt)) begin fails++; $display("FAIL neg_cnt: got %0d expected %0d", mismatch_cnt, e_cnt); end
    tests++; if (fail_vec !== 4'd2) begin fails++; $display("FAIL neg_fail_vec: got %0d expected 2", fail_vec); end
    tests++; if (fail_valid !== 1'b1) begin fails++; $display("FAIL neg_fail_valid: got %b expected 1", fail_valid); end
    tests++; if (match !== 1'b0) begin fails++; $display("FAIL neg_match: got %b expected 0", match); end
  endtask

  // Every vector fails: the count must reach 2^NI without wrapping.
  task automatic test_all_mismatch();
    int off, e_off, e_cnt; bit sq, pl;
    set_identity();
    oneg_v = 2'b11;
`ifdef BMATCH_EARLY_ABORT_EN
    e_off = 4; e_cnt = 1;
`else
    e_off = 19; e_cnt = 16;
`endif
    run_dut(off, sq, pl);
    tests++; if (off != e_off) begin fails++; $display("FAIL all_done_off: got %0d expected %0d", off, e_off); end
    tests++; if (mismatch_cnt !== 5'(e_cnt)) begin fails++; $display("FAIL all_cnt: got %0d expected %0d", mismatch_cnt, e_cnt); end
    tests++; if (fail_vec !== 4'd0 || fail_valid !== 1'b1) begin fails++; $display("FAIL all_fail: got vld=%b vec=%0d expected vld=1 vec=0", fail_valid, fail_vec); end
  endtask

  task automatic test_random();
    int off, e_off, e_cnt, e_fvld, e_fv, e_match; bit sq, pl;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) iperm_a[i] = i;
      for (int i = 3; i > 0; i--) begin
        int s, t;
        s = int'($urandom_range(0, i));
        t = iperm_a[i]; iperm_a[i] = iperm_a[s]; iperm_a[s] = t;
      end
      operm_a[0] = int'($urandom_range(0, 1)); operm_a[1] = 1 - operm_a[0];
      ineg_v = 4'($urandom); oneg_v = 2'($urandom);
      for (int v = 0; v < 16; v++) tab_a[v] = 2'($urandom);
      // Build cir2 so the mapping matches, then optionally break a few entries.
      for (int v = 0; v < 16; v++)
        for (int j = 0; j < 2; j++) tab_b[vb_of(4'(v))][operm_a[j]] = tab_a[v][j] ^ oneg_v[j];
      if (r % 2 == 1)
        for (int f = 0; f < r / 2 + 1; f++) tab_b[$urandom_range(0, 15)] ^= 2'($urandom_range(1, 3));
      model(e_off, e_cnt, e_fvld, e_fv, e_match);
      run_dut(off, sq, pl);
      tests++; if (off != e_off) begin fails++; $display("FAIL rand%0d_done_off: got %0d expected %0d", r, off, e_off); end
      tests++; if (!sq || !pl) begin fails++; $display("FAIL rand%0d_sequence: got seq=%b pulse=%b expected 1 1", r, sq, pl); end
      tests++; if (mismatch_cnt !== 5'(e_cnt)) begin fails++; $display("FAIL rand%0d_cnt: got %0d expected %0d", r, mismatch_cnt, e_cnt); end
      tests++; if (fail_valid !== 1'(e_fvld) || fail_vec !== 4'(e_fv)) begin fails++; $display("FAIL rand%0d_fail: got vld=%b vec=%0d expected vld=%0d vec=%0d", r, fail_valid, fail_vec, e_fvld, e_fv); end
      tests++; if (match !== 1'(e_match)) begin fails++; $display("FAIL rand%0d_match: got %b expected %0d", r, match, e_match); end
    end
  endtask

  task automatic test_start_while_busy();
    int k, o, off; bit ok, sq, pl;
    set_identity();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; k = cyc; ok = 1;
    while (cyc - k < 8) begin
      o = cyc - k;
      start = (o == 4);
      if (o >= 1 && vec_a !== 4'(o - 1)) ok = 0;
      if (o == 7) rst = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL busy_start_vec_a: got 0 expected 1"); end
    tests++;
    if ({vec_a, vec_b, busy, done, match, fail_valid, fail_vec, mismatch_cnt} !== '0) begin
      fails++;
      $display("FAIL midrun_reset: got %h expected 0",
               {vec_a, vec_b, busy, done, match, fail_valid, fail_vec, mismatch_cnt});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got busy=%b done=%b expected 0 0", busy, done); end
    run_dut(off, sq, pl);
    tests++; if (off != 19 || !sq || match !== 1'b1) begin fails++; $display("FAIL rerun: got off=%0d seq=%b match=%b expected 19 1 1", off, sq, match); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_input_swap();
    test_wrong_neg();
    test_all_mismatch();
    test_random();
    test_start_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
